// File: rtl/dm_access_unit.sv
// Data-memory access unit: word reads/writes with sub-word load extraction and
// read-modify-write for SB/SH. Optional alignment checking via DM_ACCESS_ALIGN_CHECK_EN.
module dm_access_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  output logic [31:0] mem_pc,
  input  logic [31:0] mem_rd
);

  localparam logic [2:0] OpLw = 3'd0, OpLh = 3'd1, OpLhu = 3'd2, OpLb = 3'd3;
  localparam logic [2:0] OpLbu = 3'd4, OpSw = 3'd5, OpSh = 3'd6, OpSb = 3'd7;

  typedef enum logic [1:0] {StIdle, StRd, StWr} state_e;

  state_e      state_q, state_d;
  logic [2:0]  op_q;
  logic [31:0] addr_q, wdata_q, pc_q;
  logic [31:0] merge_q, merge_d, rdata_q, rdata_d;
  logic        done_q, done_d, req_take;
  logic [4:0]  lane_sh;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val, merged;

  always_comb begin
    lane_sh  = {addr_q[1:0], 3'b000};
    byte_sel = mem_rd[lane_sh +: 8];
    half_sel = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];
    unique case (op_q)
      OpLh:    load_val = {{16{half_sel[15]}}, half_sel};
      OpLhu:   load_val = {16'h0000, half_sel};
      OpLb:    load_val = {{24{byte_sel[7]}}, byte_sel};
      OpLbu:   load_val = {24'h000000, byte_sel};
      default: load_val = mem_rd;
    endcase
  end

  // Merge the stored lane into the word captured during RD.
  always_comb begin
    merged = merge_q;
    if (op_q == OpSb) begin
      merged[lane_sh +: 8] = wdata_q[7:0];
    end else if (addr_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0] = wdata_q[15:0];
    end
  end

`ifdef DM_ACCESS_ALIGN_CHECK_EN
  logic err_q, err_d, misaligned;

  always_comb begin
    unique case (op)
      OpLw, OpSw:        misaligned = (addr[1:0] != 2'b00);
      OpLh, OpLhu, OpSh: misaligned = addr[0];
      default:           misaligned = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    req_take = 1'b0;
    rdata_d  = rdata_q;
    merge_d  = merge_q;
    mem_a    = 32'h0;
    mem_wd   = 32'h0;
    mem_we   = 1'b0;
    mem_pc   = 32'h0;
`ifdef DM_ACCESS_ALIGN_CHECK_EN
    err_d    = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (req) begin
          req_take = 1'b1;
`ifdef DM_ACCESS_ALIGN_CHECK_EN
          if (misaligned) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else
`endif
          if (op == OpSw) state_d = StWr;
          else            state_d = StRd;
        end
      end
      StRd: begin
        mem_a  = {addr_q[31:2], 2'b00};
        mem_pc = pc_q;
        if (op_q == OpSh || op_q == OpSb) begin
          merge_d = mem_rd;
          state_d = StWr;
        end else begin
          rdata_d = load_val;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      StWr: begin
        mem_a   = {addr_q[31:2], 2'b00};
        mem_pc  = pc_q;
        mem_we  = 1'b1;
        mem_wd  = (op_q == OpSw) ? wdata_q : merged;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      done_q  <= 1'b0;
      rdata_q <= 32'h0;
      merge_q <= 32'h0;
      op_q    <= 3'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      pc_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      merge_q <= merge_d;
      if (req_take) begin
        op_q    <= op;
        addr_q  <= addr;
        wdata_q <= wdata;
        pc_q    <= pc;
      end
    end
  end

  assign busy  = (state_q != StIdle);
  assign done  = done_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_dm_access_unit.sv
// Randomized self-checking bench for dm_access_unit against an arithmetic memory model.
// Honours DM_ACCESS_ALIGN_CHECK_EN when computing expected behaviour.
module tb_dm_access_unit;

  localparam logic [2:0] OpLw = 3'd0, OpLh = 3'd1, OpLhu = 3'd2, OpLb = 3'd3;
  localparam logic [2:0] OpLbu = 3'd4, OpSw = 3'd5, OpSh = 3'd6, OpSb = 3'd7;

  logic        clk = 1'b0;
  logic        reset, req;
  logic [2:0]  op;
  logic [31:0] addr, wdata, pc;
  logic        busy, done, err, mem_we;
  logic [31:0] rdata, mem_a, mem_wd, mem_pc, mem_rd;

  logic [31:0] mem [1024];
  logic [31:0] model_mem [1024];
  logic [31:0] exp_rdata;
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  assign mem_rd = mem[mem_a[11:2]];

  dm_access_unit dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .op     (op),
    .addr   (addr),
    .wdata  (wdata),
    .pc     (pc),
    .busy   (busy),
    .done   (done),
    .rdata  (rdata),
    .err    (err),
    .mem_a  (mem_a),
    .mem_wd (mem_wd),
    .mem_we (mem_we),
    .mem_pc (mem_pc),
    .mem_rd (mem_rd)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Issue one request and watch five cycles; optionally pulse req while busy.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] p, input bit poke);
    logic [31:0] word, v, mask, exp_wd, wr_a, wr_d, wr_pc, got_rd, got_err;
    int          sh, exp_done, exp_wr, n_wr, n_done, done_cyc, wr_cyc;
    bit          mis;
    word = model_mem[a[11:2]];
    mis = 1'b0;
    exp_wr = 0;
    exp_wd = 32'h0;
    exp_done = 2;
`ifdef DM_ACCESS_ALIGN_CHECK_EN
    if ((o == OpLw || o == OpSw) && (a % 4) != 0) mis = 1'b1;
    if ((o == OpLh || o == OpLhu || o == OpSh) && (a % 2) != 0) mis = 1'b1;
`endif
    if (mis) begin
      exp_done = 1;
    end else begin
      case (o)
        OpLw: exp_rdata = word;
        OpLh, OpLhu: begin
          sh = 16 * ((a / 2) % 2);
          v = (word >> sh) & 32'hFFFF;
          if (o == OpLh && v >= 32'h8000) v = v + 32'hFFFF0000;
          exp_rdata = v;
        end
        OpLb, OpLbu: begin
          sh = 8 * (a % 4);
          v = (word >> sh) & 32'hFF;
          if (o == OpLb && v >= 32'h80) v = v + 32'hFFFFFF00;
          exp_rdata = v;
        end
        OpSw: begin
          exp_wr = 1;
          exp_wd = wd;
        end
        default: begin
          sh = (o == OpSh) ? 16 * ((a / 2) % 2) : 8 * (a % 4);
          mask = ((o == OpSh) ? 32'hFFFF : 32'hFF) << sh;
          exp_wd = (word & ~mask) | ((wd << sh) & mask);
          exp_wr = 1;
          exp_done = 3;
        end
      endcase
    end
    if (exp_wr == 1) model_mem[a[11:2]] = exp_wd;

    req = 1'b1; op = o; addr = a; wdata = wd; pc = p;
    @(posedge clk);
    #1;
    req = 1'b0; op = 3'($urandom); addr = $urandom; wdata = $urandom; pc = $urandom;
    n_wr = 0; n_done = 0; done_cyc = 0; wr_cyc = 0;
    wr_a = 0; wr_d = 0; wr_pc = 0; got_rd = 0; got_err = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (mem_we) begin
        n_wr++;
        wr_cyc = c; wr_a = mem_a; wr_d = mem_wd; wr_pc = mem_pc;
        mem[mem_a[11:2]] = mem_wd;
      end
      if (done) begin
        n_done++;
        done_cyc = c; got_rd = rdata; got_err = {31'h0, err};
      end
      if (poke && !mis && c == 1) begin
        req = 1'b1; op = OpLw; addr = $urandom_range(0, 4095);
      end
      if (c == 2) req = 1'b0;
    end
    check_eq("done_count", n_done, 1);
    check_eq("done_cycle", done_cyc, exp_done);
    check_eq("write_count", n_wr, exp_wr);
    if (exp_wr == 1) begin
      check_eq("write_cycle", wr_cyc, exp_done - 1);
      check_eq("write_addr", wr_a, a & 32'hFFFFFFFC);
      check_eq("write_data", wr_d, exp_wd);
      check_eq("write_pc", wr_pc, p);
    end
    check_eq("rdata", got_rd, exp_rdata);
    check_eq("err", got_err, {31'h0, mis});
    check_eq("idle_busy", busy, 0);
    check_eq("idle_mem_a", mem_a, 0);
  endtask

  initial begin
    int n_we, n_dn;
    reset = 1'b1; req = 1'b0; op = 3'd0; addr = 0; wdata = 0; pc = 0;
    exp_rdata = 32'h0;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = $urandom;
      model_mem[i] = mem[i];
    end
    mem[32'h100 >> 2] = 32'h8899AABB;
    model_mem[32'h100 >> 2] = 32'h8899AABB;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_mem_we", mem_we, 0);
    check_eq("rst_rdata", rdata, 0);
    check_eq("rst_mem_a", mem_a, 0);
    check_eq("rst_mem_wd", mem_wd, 0);
    check_eq("rst_mem_pc", mem_pc, 0);
    reset = 1'b0;

    run_op(OpLb, 32'h103, 32'h0, 32'h1000, 1'b0);
    check_eq("plan_lb", rdata, 32'hFFFFFF88);
    run_op(OpLbu, 32'h103, 32'h0, 32'h1004, 1'b0);
    check_eq("plan_lbu", rdata, 32'h00000088);
    run_op(OpLh, 32'h102, 32'h0, 32'h1008, 1'b0);
    check_eq("plan_lh", rdata, 32'hFFFF8899);
    run_op(OpSw, 32'h200, 32'h12345678, 32'h100C, 1'b0);
    run_op(OpSb, 32'h201, 32'hFFFFFFAB, 32'h1010, 1'b0);
    check_eq("plan_sb_word", mem[32'h200 >> 2], 32'h1234AB78);
    run_op(OpSh, 32'h202, 32'h0000CDEF, 32'h1014, 1'b1);
    check_eq("plan_sh_word", mem[32'h200 >> 2], 32'hCDEFAB78);
    run_op(OpLw, 32'h102, 32'h0, 32'h1018, 1'b0);

    // Reset while an SB sits in RD: nothing may be written or completed.
    req = 1'b1; op = OpSb; addr = 32'h301; wdata = 32'h55; pc = 32'h2000;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    check_eq("rstmid_rd_we", mem_we, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_rdata = 32'h0;
    check_eq("rstmid_busy", busy, 0);
    check_eq("rstmid_done", done, 0);
    check_eq("rstmid_rdata", rdata, 0);
    check_eq("rstmid_mem_a", mem_a, 0);
    check_eq("rstmid_mem_wd", mem_wd, 0);
    check_eq("rstmid_mem_pc", mem_pc, 0);
    n_we = 0; n_dn = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (mem_we) n_we++;
      if (done) n_dn++;
    end
    check_eq("rstmid_no_write", n_we, 0);
    check_eq("rstmid_no_done", n_dn, 0);
    check_eq("rstmid_mem", mem[32'h300 >> 2], model_mem[32'h300 >> 2]);

    for (int i = 0; i < 60; i++) begin
      run_op(3'($urandom_range(0, 7)), $urandom_range(0, 4095), $urandom, $urandom,
             1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dm_access_unit.md
# dm_access_unit

Processor-side initiator for the word-wide data memory: accepts a single load/store request from the MEM stage, issues word reads/writes, and performs sub-word extraction (lb/lbu/lh/lhu) and read-modify-write merging (sb/sh). The data memory only supports full-word writes, so this block owns byte and halfword semantics. It sits between the MEM stage and the data memory and drives the memory's address, write-data, write-enable and PC-trace inputs.

## Interface
Parameters:
- none

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; one clock, reset sampled on rising edge of clk
- req  input  1  request strobe, sampled only in IDLE
- op  input  3  0=LW 1=LH 2=LHU 3=LB 4=LBU 5=SW 6=SH 7=SB
- addr  input  32  byte address
- wdata  input  32  store data; low byte/halfword used for SB/SH
- pc  input  32  PC of the requesting instruction, captured with req
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle completion pulse
- rdata  output  32  load result, extended, valid while done=1 and held until next done
- err  output  1  misaligned-access flag, pulses with done
- mem_a  output  32  word address to memory (low 2 bits always 0)
- mem_wd  output  32  write data to memory
- mem_we  output  1  memory write enable
- mem_pc  output  32  captured PC forwarded for the memory's write trace
- mem_rd  input  32  combinational read data from memory for mem_a

## Operation
- States: IDLE, RD, WR. Request latched (op, addr, wdata, pc) on the edge where state=IDLE and req=1.
- LW/LH/LHU/LB/LBU: IDLE -> RD -> IDLE. In RD, mem_a = {addr[31:2],2'b00}; mem_rd is sampled, lane-selected and extended into rdata at the end of RD.
- SW: IDLE -> WR -> IDLE; mem_wd = wdata.
- SH/SB: IDLE -> RD -> WR -> IDLE; RD captures mem_rd into merge register; WR drives merged word.
- Byte lanes little-endian: addr[1:0]=0 selects bits[7:0], 3 selects [31:24]; halfword addr[1]=0 selects [15:0].
- LB/LH sign-extend; LBU/LHU zero-extend.
- mem_we=1 only in WR, exactly one cycle per store. mem_a/mem_wd/mem_pc = 0 in IDLE.
- req while busy is ignored (no queueing); requester must hold off until done.
- done and err registered; rdata untouched by stores and by errored requests.

## Timing
- Reset: state=IDLE; busy, done, err, mem_we = 0; rdata, mem_a, mem_wd, mem_pc = 0.
- Request at edge N: LW/Lx done at N+2, SW done at N+2, SH/SB done at N+3 (write occurs at edge N+2).
- done high for exactly one cycle; new req may be presented in the same cycle done is high (state already IDLE).
- Reset mid-operation: state->IDLE at that edge, pending store abandoned, no done pulse, mem_we low from the next cycle.
- A write in WR and reset on the same edge: memory write outcome is the memory's concern; this block returns to IDLE.

## Configuration
- DM_ACCESS_ALIGN_CHECK_EN defined: LW/SW with addr[1:0]!=0 or LH/LHU/SH with addr[0]!=0 perform no memory access; block goes IDLE -> IDLE, done=1 and err=1 one cycle later, rdata unchanged.
- Not defined: err tied 0; low address bits beyond the access size are ignored (halfword uses addr[1], word uses none) and the access proceeds normally.

## Test plan
- Memory word 0x100 = 0x8899AABB; LB addr 0x103 -> rdata 0xFFFFFF88 at done; LBU addr 0x103 -> 0x00000088; LH addr 0x102 -> 0xFFFF8899.
- SW addr 0x200 wdata 0x12345678 -> mem_we high for one cycle with mem_a=0x200, mem_wd=0x12345678; done two cycles after req.
- Memory 0x200 = 0x12345678; SB addr 0x201 wdata 0xFFFFFFAB -> single write 0x1234AB78 at cycle 2 after req, done at cycle 3; SH addr 0x202 wdata 0xCDEF -> 0xCDEFAB78.
- req pulsed again while busy during SH -> ignored, exactly one write and one done.
- Reset asserted in RD of an SB -> no mem_we ever asserted, no done, all outputs 0 next cycle.
- With DM_ACCESS_ALIGN_CHECK_EN: LW addr 0x102 -> done=1, err=1, no mem access; without macro: same request reads word 0x100.
